// File: rtl/cluster_packer_iter_pkg.sv
// Shared types and helpers for the iterative cluster packer.
package cluster_packer_iter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    EXTRACT = 1'b1
  } state_t;

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int invalid_adr(int adrbits);
    return (1 << adrbits) - 2;
  endfunction

endpackage

// File: rtl/cluster_pri_enc.sv
// Find-first-set over N bits; rev_i=1 searches from the MSB down.
module cluster_pri_enc #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  input  logic          rev_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_o) begin
        if (rev_i ? vec_i[N-1-i] : vec_i[i]) begin
          found_o = 1'b1;
          idx_o   = rev_i ? IW'(N-1-i) : IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cluster_packer_iter.sv
// Per-BX S-bit cluster finder: vpf/cnt front end, then
// ENC_PER_CLK chained encoders iterated over E clock4x cycles.
module cluster_packer_iter
  import cluster_packer_iter_pkg::*;
#(
  parameter int NVFATS      = 24,
  parameter int MXSBITS     = 64,
  parameter int NROWS       = 8,
  parameter int MXCNTBITS   = 3,
  parameter int MXADRBITS   = 11,
  parameter int MXCLUSTERS  = 8,
  parameter int ENC_PER_CLK = 4,
  parameter int BX_CLOCKS   = 4
) (
  input  logic clock4x,
  input  logic global_reset,
  input  logic bx_strobe,
  input  logic [MXSBITS*NVFATS-1:0] sbits,
  input  logic truncate_clusters,
  input  logic reverse_priority_order,
  output logic [MXCLUSTERS*(MXCNTBITS+MXADRBITS)-1:0] clusters,
  output logic [MXCLUSTERS-1:0] cluster_valid,
  output logic [$clog2(MXCLUSTERS+1)-1:0] cluster_count,
  output logic overflow,
  output logic out_valid
);

  localparam int NPADS = MXSBITS * NVFATS;
  localparam int KEYS  = NPADS / NROWS;
  localparam int JN    = NVFATS / NROWS;
  localparam int CLSZ  = 1 << MXCNTBITS;
  localparam int O     = CLSZ + 1;
  localparam int HXW   = KEYS + 2 * CLSZ;
  localparam int W     = MXCNTBITS + MXADRBITS;
  localparam int EPC   = ENC_PER_CLK;
  localparam int MX    = MXCLUSTERS;
  localparam int E     = ceil_div(MX, EPC);
  localparam int IW    = $clog2(NPADS);
  localparam int CW    = $clog2(MX + 1);
  localparam int SW    = (MX > 1) ? $clog2(MX) : 1;
  localparam int ITW   = $clog2(E + 1);
  localparam logic [MXADRBITS-1:0] INV =
    MXADRBITS'(invalid_adr(MXADRBITS));

  if (NVFATS % NROWS != 0) begin : g_err_rows
    $error("NVFATS must be a multiple of NROWS");
  end
  if (E > BX_CLOCKS - 1) begin : g_err_iter
    $error("extraction does not fit in one BX");
  end
  if ((1 << MXADRBITS) < NPADS + 2) begin : g_err_adr
    $error("MXADRBITS too small for NPADS");
  end

  // Each row is zero-padded so neighbour lookups never leave it.
  logic [NROWS-1:0][HXW-1:0] hx;

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    logic [KEYS-1:0] row;
    for (genvar j = 0; j < JN; j++) begin : g_vf
      assign row[j*MXSBITS +: MXSBITS] =
        sbits[(r + j*NROWS)*MXSBITS +: MXSBITS];
    end
    assign hx[r] = {{(CLSZ-1){1'b0}}, row, {O{1'b0}}};
  end

  logic [NPADS-1:0] vpf;
  logic [NPADS-1:0][MXCNTBITS-1:0] cnt_c;
  logic run;
  logic [MXCNTBITS-1:0] c;

  always_comb begin
    vpf   = '0;
    cnt_c = '0;
    run   = 1'b0;
    c     = '0;
    for (int r = 0; r < NROWS; r++) begin
      for (int k = 0; k < KEYS; k++) begin
        vpf[r*KEYS+k] = hx[r][k+O] &
          (~hx[r][k+O-1] |
           (~truncate_clusters &
            (&hx[r][k+O-1 -: CLSZ]) &
            ~hx[r][k+O-1-CLSZ]));
        run = 1'b1;
        c   = '0;
        for (int i = 1; i < CLSZ; i++) begin
          run = run & hx[r][k+O+i];
          c   = c + MXCNTBITS'(run);
        end
        cnt_c[r*KEYS+k] = c;
      end
    end
  end

  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [NPADS-1:0] mask_q, mask_d;
  logic [NPADS-1:0][MXCNTBITS-1:0] cnt_q;
  logic rev_q, rev_d;
  logic [CW-1:0] nfill_q, nfill_d;
  logic [MX-1:0][MXADRBITS-1:0] sadr_q, sadr_d;
  logic [MX-1:0][MXCNTBITS-1:0] scnt_q, scnt_d;
  logic [MX-1:0] svld_q, svld_d;
  logic [MX*W-1:0] clus_q, clus_d;
  logic [MX-1:0] vld_q, vld_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic ovf_q, ovf_d;
  logic ov_q, ov_d;

  logic ext;
  logic [EPC-1:0] take_v;
  logic [IW-1:0] idx_v [EPC];
  logic [NPADS-1:0] mask_ext;

  assign ext = (state_q == EXTRACT);

  // Each encoder sees the previous one's mask with its hit removed.
  for (genvar e = 0; e < EPC; e++) begin : g_enc
    logic [NPADS-1:0] m_in, m_out;
    logic [IW-1:0] idx;
    logic found, take;
    if (e == 0) begin : g_first
      assign m_in = ext ? mask_q : '0;
    end else begin : g_next
      assign m_in = g_enc[e-1].m_out;
    end
    cluster_pri_enc #(.N(NPADS)) u_enc (
      .vec_i  (m_in),
      .rev_i  (rev_q),
      .idx_o  (idx),
      .found_o(found)
    );
    assign take  = found & (int'(nfill_q) + e < MX);
    assign m_out = m_in & ~(NPADS'(take) << idx);
    assign take_v[e] = take;
    assign idx_v[e]  = idx;
    if (e == EPC - 1) begin : g_last
      assign mask_ext = m_out;
    end
  end

  logic [CW-1:0] fill;
  logic emit_norm, flush;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    iter_d  = iter_q;
    mask_d  = mask_q;
    rev_d   = rev_q;
    sadr_d  = sadr_q;
    scnt_d  = scnt_q;
    svld_d  = svld_q;
    clus_d  = clus_q;
    vld_d   = vld_q;
    ccnt_d  = ccnt_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    fill    = nfill_q;
    for (int e = 0; e < EPC; e++) begin
      if (take_v[e]) begin
        sadr_d[SW'(fill)] = MXADRBITS'(idx_v[e]);
        scnt_d[SW'(fill)] = cnt_q[idx_v[e]];
        svld_d[SW'(fill)] = 1'b1;
        fill = fill + CW'(1);
      end
    end
    nfill_d   = fill;
    emit_norm = pend_q && (iter_q == ITW'(E));
    flush     = bx_strobe && pend_q;
    if (emit_norm || flush) begin
      for (int s = 0; s < MX; s++) begin
        clus_d[s*W +: W] = {scnt_d[s], sadr_d[s]};
      end
      vld_d  = svld_d;
      ccnt_d = fill;
      ovf_d  = (flush & ext) | (|mask_ext);
      ov_d   = 1'b1;
    end
    if (bx_strobe) begin
      state_d = EXTRACT;
      pend_d  = 1'b1;
      iter_d  = ITW'(1);
      mask_d  = vpf;
      rev_d   = reverse_priority_order;
      nfill_d = '0;
      svld_d  = '0;
      scnt_d  = '0;
      sadr_d  = {MX{INV}};
    end else if (pend_q) begin
      mask_d = mask_ext;
      if (emit_norm) begin
        state_d = IDLE;
        pend_d  = 1'b0;
        mask_d  = '0;
      end else begin
        iter_d  = iter_q + ITW'(1);
        state_d = (ext && |mask_ext) ? EXTRACT : IDLE;
      end
    end
  end

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      iter_q  <= '0;
      mask_q  <= '0;
      rev_q   <= 1'b0;
      nfill_q <= '0;
      sadr_q  <= {MX{INV}};
      scnt_q  <= '0;
      svld_q  <= '0;
      clus_q  <= {MX{{MXCNTBITS'(0), INV}}};
      vld_q   <= '0;
      ccnt_q  <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      iter_q  <= iter_d;
      mask_q  <= mask_d;
      rev_q   <= rev_d;
      nfill_q <= nfill_d;
      sadr_q  <= sadr_d;
      scnt_q  <= scnt_d;
      svld_q  <= svld_d;
      clus_q  <= clus_d;
      vld_q   <= vld_d;
      ccnt_q  <= ccnt_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  always_ff @(posedge clock4x) begin
    if (bx_strobe && !global_reset) begin
      cnt_q <= cnt_c;
    end
  end

  assign clusters      = clus_q;
  assign cluster_valid = vld_q;
  assign cluster_count = ccnt_q;
  assign overflow      = ovf_q;
  assign out_valid     = ov_q;

endmodule

// File: tb/tb_cluster_packer_iter.sv
// Directed bench for cluster_packer_iter at default parameters.
module tb_cluster_packer_iter;

  localparam int NPADS = 1536;
  localparam int MX    = 8;
  localparam int W     = 14;
  localparam int INV   = 2046;
  localparam int NV    = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic global_reset;
  logic bx_strobe;
  logic [NPADS-1:0] sbits;
  logic truncate_clusters;
  logic reverse_priority_order;
  logic [MX*W-1:0] clusters;
  logic [MX-1:0] cluster_valid;
  logic [3:0] cluster_count;
  logic overflow;
  logic out_valid;

  cluster_packer_iter dut (
    .clock4x               (clk),
    .global_reset          (global_reset),
    .bx_strobe             (bx_strobe),
    .sbits                 (sbits),
    .truncate_clusters     (truncate_clusters),
    .reverse_priority_order(reverse_priority_order),
    .clusters              (clusters),
    .cluster_valid         (cluster_valid),
    .cluster_count         (cluster_count),
    .overflow              (overflow),
    .out_valid             (out_valid)
  );

  typedef struct packed {
    logic [NPADS-1:0] sb;
    logic tr;
    logic rv;
    logic [3:0] n;
    logic ov;
    logic [MX-1:0][10:0] adr;
    logic [MX-1:0][2:0] cn;
  } vec_t;

  vec_t vt [NV];
  int total = 0;
  int bad = 0;

  function automatic int pd(int v, int b);
    return v * 64 + b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_slots(input string tag, input vec_t v);
    logic [W-1:0] wd;
    for (int s = 0; s < MX; s++) begin
      wd = clusters[s*W +: W];
      chk($sformatf("%s vld%0d", tag, s),
          int'(cluster_valid[s]), (s < int'(v.n)) ? 1 : 0);
      chk($sformatf("%s adr%0d", tag, s), int'(wd[10:0]),
          (s < int'(v.n)) ? int'(v.adr[s]) : INV);
      chk($sformatf("%s cnt%0d", tag, s), int'(wd[13:11]),
          (s < int'(v.n)) ? int'(v.cn[s]) : 0);
    end
    chk({tag, " count"}, int'(cluster_count), int'(v.n));
    chk({tag, " ovf"}, int'(overflow), int'(v.ov));
  endtask

  task automatic strobe(input logic [NPADS-1:0] sb,
                        input logic tr, input logic rv);
    sbits = sb;
    truncate_clusters = tr;
    reverse_priority_order = rv;
    bx_strobe = 1'b1;
    tick();
    bx_strobe = 1'b0;
    sbits = '0;
  endtask

  vec_t z;
  vec_t t;

  initial begin
    global_reset = 1'b1;
    bx_strobe = 1'b0;
    sbits = '0;
    truncate_clusters = 1'b0;
    reverse_priority_order = 1'b0;

    for (int i = 0; i < NV; i++) vt[i] = '0;
    z = '0;
    vt[0].sb[pd(0, 5)] = 1'b1;
    vt[0].n = 1; vt[0].adr[0] = 5;
    vt[1].sb[pd(8, 62)] = 1'b1;
    vt[1].sb[pd(8, 63)] = 1'b1;
    vt[1].sb[pd(16, 0)] = 1'b1;
    vt[1].n = 1; vt[1].adr[0] = 126; vt[1].cn[0] = 2;
    vt[2].sb[pd(16, 63)] = 1'b1;
    vt[2].sb[pd(1, 0)] = 1'b1;
    vt[2].n = 2; vt[2].adr[0] = 191; vt[2].adr[1] = 192;
    for (int b = 0; b < 12; b++) vt[3].sb[pd(0, b)] = 1'b1;
    vt[3].n = 2; vt[3].adr[0] = 0; vt[3].cn[0] = 7;
    vt[3].adr[1] = 8; vt[3].cn[1] = 3;
    vt[4].sb = vt[3].sb; vt[4].tr = 1'b1;
    vt[4].n = 1; vt[4].adr[0] = 0; vt[4].cn[0] = 7;
    for (int b = 0; b <= 16; b += 2) vt[5].sb[pd(0, b)] = 1'b1;
    vt[5].n = 8; vt[5].ov = 1'b1;
    for (int s = 0; s < MX; s++) vt[5].adr[s] = 11'(2 * s);
    vt[6].sb = vt[5].sb; vt[6].rv = 1'b1;
    vt[6].n = 8; vt[6].ov = 1'b1;
    for (int s = 0; s < MX; s++) vt[6].adr[s] = 11'(16 - 2 * s);
    vt[8].sb[pd(23, 63)] = 1'b1;
    vt[8].n = 1; vt[8].adr[0] = 1535;

    repeat (3) tick();
    global_reset = 1'b0;
    tick();
    chk("rst out_valid", int'(out_valid), 0);
    chk_slots("rst", z);

    for (int i = 0; i < NV; i++) begin
      strobe(vt[i].sb, vt[i].tr, vt[i].rv);
      tick();
      chk($sformatf("v%0d early", i), int'(out_valid), 0);
      tick();
      chk($sformatf("v%0d out_valid", i), int'(out_valid), 1);
      chk_slots($sformatf("v%0d", i), vt[i]);
      tick();
      chk($sformatf("v%0d pulse", i), int'(out_valid), 0);
      tick();
    end

    strobe(vt[0].sb, 1'b0, 1'b0);
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("midrst c%0d", c), int'(out_valid), 0);
      tick();
    end
    chk_slots("midrst", z);

    global_reset = 1'b1;
    sbits = vt[0].sb;
    bx_strobe = 1'b1;
    tick();
    global_reset = 1'b0;
    bx_strobe = 1'b0;
    sbits = '0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rststb c%0d", c), int'(out_valid), 0);
      tick();
    end

    strobe(vt[0].sb, 1'b0, 1'b0);
    t = '0;
    t.sb[pd(0, 9)] = 1'b1;
    strobe(t.sb, 1'b0, 1'b0);
    chk("b2b flush valid", int'(out_valid), 1);
    t.n = 1; t.adr[0] = 5; t.ov = 1'b1;
    chk_slots("b2b flush", t);
    tick();
    chk("b2b gap", int'(out_valid), 0);
    tick();
    chk("b2b second valid", int'(out_valid), 1);
    t.adr[0] = 9; t.ov = 1'b0;
    chk_slots("b2b second", t);
    tick();
    chk("b2b end", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
